pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 4-stage core (F, D, E, W). It produces the 2-bit `update` commands consumed by the F/D, D/E and E/W pipeline registers and the PC enable/redirect. It sequences the following:
- multi-cycle execute occupancy, from `de_wait_time`;
- load-use bubbles;
- taken branch/jump flushes;
- external memory stalls;
- the `stop` halt/resume handshake.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/hazard_detect.sv | 27 ++
 rtl/pipeline_ctrl.sv | 104 ++++++++++
 tb/tb_pipeline_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline stall/flush controller.
package pipe_pkg;

   // Pipeline register update commands
   localparam logic [1:0] UPD_HOLD  = 2'b00;
   localparam logic [1:0] UPD_ADV   = 2'b01;
   localparam logic [1:0] UPD_FLUSH = 2'b10;

   // E-stage op class marking a load
   localparam logic [1:0] OP_LOAD   = 2'b01;

   typedef enum logic [1:0] {
      RUN,
      EXEC_WAIT,
      HALT
   } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: D-stage sources against the E-stage load destination.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [5:0] d_rs_i,
   input  logic [5:0] d_rt_i,
   input  logic       d_use_s_i,
   input  logic       d_use_t_i,
   input  logic [1:0] de_rw_i,
   input  logic [4:0] de_rd_i,
   input  logic [1:0] de_op_type_i,
   output logic       load_use_o
);

   logic [5:0] e_dst;
   logic       s_hit;
   logic       t_hit;

   // Register file select is bit 1 of the write type, as in the forwarding unit
   always_comb begin
      e_dst      = {de_rw_i[1], de_rd_i};
      s_hit      = d_use_s_i && (d_rs_i == e_dst);
      t_hit      = d_use_t_i && (d_rt_i == e_dst);
      load_use_o = (de_op_type_i == OP_LOAD) && (de_rw_i != 2'b00) && (s_hit || t_hit);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 4-stage core (F, D, E, W).
module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned WAIT_W = 5
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [5:0]        d_rs,
   input  logic [5:0]        d_rt,
   input  logic              d_use_s,
   input  logic              d_use_t,
   input  logic [1:0]        de_rw,
   input  logic [4:0]        de_rd,
   input  logic [1:0]        de_op_type,
   input  logic [WAIT_W-1:0] de_wait_time,
   input  logic              de_stop,
   input  logic              e_taken,
   input  logic              mem_busy,
   input  logic              go,
   output logic              pc_en,
   output logic              pc_redirect,
   output logic [1:0]        fd_update,
   output logic [1:0]        de_update,
   output logic [1:0]        ew_update,
   output logic              halted
);

   ctrl_state_t       state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              load_use;

   hazard_detect u_hazard (
      .d_rs_i       (d_rs),
      .d_rt_i       (d_rt),
      .d_use_s_i    (d_use_s),
      .d_use_t_i    (d_use_t),
      .de_rw_i      (de_rw),
      .de_rd_i      (de_rd),
      .de_op_type_i (de_op_type),
      .load_use_o   (load_use)
   );

   // Output decode and next-state selection, highest priority first
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fd_update   = UPD_HOLD;
      de_update   = UPD_HOLD;
      ew_update   = UPD_HOLD;
      pc_en       = 1'b0;
      pc_redirect = 1'b0;
      halted      = 1'b0;
      if (!rstn) begin
         state_d = RUN;
         cnt_d   = '0;
      end else if (state_q == HALT) begin
         halted = 1'b1;
         if (go) begin
            de_update = UPD_FLUSH;
            state_d   = RUN;
         end
      end else if (mem_busy) begin
         // full freeze: state and cnt hold
      end else if (state_q == RUN && de_wait_time != '0) begin
         ew_update = UPD_FLUSH;
         cnt_d     = de_wait_time - WAIT_W'(1);
         state_d   = EXEC_WAIT;
      end else if (state_q == EXEC_WAIT && cnt_q != '0) begin
         ew_update = UPD_FLUSH;
         cnt_d     = cnt_q - WAIT_W'(1);
      end else begin
         // completion cycle; a taken branch squashes D, so it outranks the hazard
         state_d   = RUN;
         ew_update = UPD_ADV;
         if (de_stop) begin
            state_d = HALT;
         end else if (e_taken) begin
            fd_update   = UPD_FLUSH;
            de_update   = UPD_FLUSH;
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
         end else if (load_use) begin
            de_update = UPD_FLUSH;
         end else begin
            fd_update = UPD_ADV;
            de_update = UPD_ADV;
            pc_en     = 1'b1;
         end
      end
   end

   // State and wait counter registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random stimulus
// checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;
   import pipe_pkg::*;

   logic       clk = 1'b0;
   logic       rstn;
   logic [5:0] d_rs, d_rt;
   logic       d_use_s, d_use_t;
   logic [1:0] de_rw;
   logic [4:0] de_rd;
   logic [1:0] de_op_type;
   logic [4:0] de_wait_time;
   logic       de_stop, e_taken, mem_busy, go;
   logic       pc_en, pc_redirect, halted;
   logic [1:0] fd_update, de_update, ew_update;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // model: is the core halted, how many cycles the current E instruction has spent, and its wait
   bit m_halted  = 1'b0;
   int m_elapsed = 0;
   int m_need    = 0;
   bit n_halted;
   int n_elapsed;
   int n_need;
   logic [8:0] exp_v;
   logic [8:0] last_out;

   pipeline_ctrl #(.WAIT_W(5)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .d_rs         (d_rs),
      .d_rt         (d_rt),
      .d_use_s      (d_use_s),
      .d_use_t      (d_use_t),
      .de_rw        (de_rw),
      .de_rd        (de_rd),
      .de_op_type   (de_op_type),
      .de_wait_time (de_wait_time),
      .de_stop      (de_stop),
      .e_taken      (e_taken),
      .mem_busy     (mem_busy),
      .go           (go),
      .pc_en        (pc_en),
      .pc_redirect  (pc_redirect),
      .fd_update    (fd_update),
      .de_update    (de_update),
      .ew_update    (ew_update),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [8:0] pack(input bit h, input bit pe, input bit pr,
                                       input logic [1:0] f, input logic [1:0] d, input logic [1:0] e);
      return {h, pe, pr, f, d, e};
   endfunction

   // Expected outputs and next model state from the current inputs
   task automatic model_eval();
      bit hz;
      int need;
      hz = (de_op_type == OP_LOAD) && (de_rw != 2'd0) &&
           ((d_use_s && d_rs[5] == de_rw[1] && d_rs[4:0] == de_rd) ||
            (d_use_t && d_rt[5] == de_rw[1] && d_rt[4:0] == de_rd));
      n_halted  = m_halted;
      n_elapsed = m_elapsed;
      n_need    = m_need;
      exp_v     = '0;
      if (!rstn) begin
         n_halted  = 1'b0;
         n_elapsed = 0;
      end else if (m_halted) begin
         exp_v = pack(1, 0, 0, UPD_HOLD, go ? UPD_FLUSH : UPD_HOLD, UPD_HOLD);
         if (go) begin
            n_halted  = 1'b0;
            n_elapsed = 0;
         end
      end else if (mem_busy) begin
         exp_v = '0;
      end else begin
         need = (m_elapsed == 0) ? int'(de_wait_time) : m_need;
         if (m_elapsed < need) begin
            exp_v     = pack(0, 0, 0, UPD_HOLD, UPD_HOLD, UPD_FLUSH);
            n_elapsed = m_elapsed + 1;
            n_need    = need;
         end else begin
            n_elapsed = 0;
            if (de_stop) begin
               exp_v    = pack(0, 0, 0, UPD_HOLD, UPD_HOLD, UPD_ADV);
               n_halted = 1'b1;
            end else if (e_taken)
               exp_v = pack(0, 1, 1, UPD_FLUSH, UPD_FLUSH, UPD_ADV);
            else if (hz)
               exp_v = pack(0, 0, 0, UPD_HOLD, UPD_FLUSH, UPD_ADV);
            else
               exp_v = pack(0, 1, 0, UPD_ADV, UPD_ADV, UPD_ADV);
         end
      end
   endtask

   // One clock: inputs already driven after negedge; check, clock, advance model
   task automatic do_cycle(input string tag);
      #1;
      model_eval();
      last_out = pack(halted, pc_en, pc_redirect, fd_update, de_update, ew_update);
      chk(tag, 16'(last_out), 16'(exp_v));
      @(posedge clk);
      m_halted  = n_halted;
      m_elapsed = n_elapsed;
      m_need    = n_need;
      @(negedge clk);
   endtask

   task automatic set_idle();
      rstn = 1; d_rs = '0; d_rt = '0; d_use_s = 0; d_use_t = 0;
      de_rw = '0; de_rd = '0; de_op_type = '0; de_wait_time = '0;
      de_stop = 0; e_taken = 0; mem_busy = 0; go = 0;
   endtask

   // Run a wait=3 instruction, optionally busy on two mid-wait cycles; return cycles to completion
   task automatic run_wait3(input bit with_busy, output int occ);
      occ = 0;
      set_idle();
      de_wait_time = 5'd3;
      for (int i = 0; i < 20; i++) begin
         mem_busy = with_busy && (i == 1 || i == 2);
         do_cycle("wait");
         occ++;
         if (last_out[1:0] == UPD_ADV) break;
      end
      set_idle();
   endtask

   initial begin
      int occ;
      set_idle();
      rstn = 0;
      @(negedge clk);
      do_cycle("rst");
      chk("rst_out", 16'(last_out), 16'h0);
      set_idle();
      do_cycle("idle");
      chk("first_adv", 16'(last_out), 16'(pack(0, 1, 0, UPD_ADV, UPD_ADV, UPD_ADV)));

      run_wait3(0, occ);
      chk("occ_wait3", 16'(occ), 16'd4);
      run_wait3(1, occ);
      chk("occ_wait3_busy", 16'(occ), 16'd6);

      // load-use, same file
      de_op_type = OP_LOAD; de_rw = 2'b01; de_rd = 5'd7; d_rs = 6'h07; d_use_s = 1;
      do_cycle("lu");
      chk("lu_upd", 16'(last_out[5:0]), 16'({UPD_HOLD, UPD_FLUSH, UPD_ADV}));
      d_rs = 6'h27;
      do_cycle("lu_other_file");
      chk("lu_other_upd", 16'(last_out[5:0]), 16'({UPD_ADV, UPD_ADV, UPD_ADV}));
      d_rs = 6'h07; e_taken = 1;
      do_cycle("taken_lu");
      chk("taken_lu_upd", 16'(last_out[6:0]), 16'({1'b1, UPD_FLUSH, UPD_FLUSH, UPD_ADV}));
      set_idle();

      // stop, halt with toggling busy, then go
      de_stop = 1;
      do_cycle("stop");
      chk("stop_ew", 16'(last_out[1:0]), 16'(UPD_ADV));
      set_idle();
      for (int i = 0; i < 10; i++) begin
         mem_busy = i[0];
         do_cycle("halt");
         chk("halt_hold", 16'(last_out), 16'(pack(1, 0, 0, UPD_HOLD, UPD_HOLD, UPD_HOLD)));
      end
      mem_busy = 0; go = 1;
      do_cycle("go");
      chk("go_de", 16'(last_out[3:2]), 16'(UPD_FLUSH));
      go = 0;
      do_cycle("resume");
      chk("resume_adv", 16'(last_out), 16'(pack(0, 1, 0, UPD_ADV, UPD_ADV, UPD_ADV)));

      // reset while waiting with cnt=2
      de_wait_time = 5'd4;
      do_cycle("w4a");
      do_cycle("w4b");
      rstn = 0;
      do_cycle("rst_mid");
      set_idle();
      do_cycle("after_rst");
      chk("after_rst_adv", 16'(last_out), 16'(pack(0, 1, 0, UPD_ADV, UPD_ADV, UPD_ADV)));

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rstn         = ($urandom_range(63) != 0);
         d_rs         = {1'($urandom), 5'($urandom_range(3))};
         d_rt         = {1'($urandom), 5'($urandom_range(3))};
         d_use_s      = 1'($urandom);
         d_use_t      = 1'($urandom);
         de_rw        = 2'($urandom);
         de_rd        = 5'($urandom_range(3));
         de_op_type   = 2'($urandom);
         de_wait_time = ($urandom_range(3) == 0) ? 5'($urandom_range(4, 1)) : 5'd0;
         de_stop      = ($urandom_range(31) == 0);
         e_taken      = ($urandom_range(3) == 0);
         mem_busy     = ($urandom_range(7) == 0);
         go           = ($urandom_range(7) == 0);
         do_cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
